// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian signal controller: FSM encoding,
// default timing constants and the vehicle-lamp sanity helper.
package ped_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_WALK_CYCLES     = 6;
  localparam int unsigned DEF_FLASH_CYCLES    = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RED = 2'd1,
    ST_WALK     = 2'd2,
    ST_FLASH    = 2'd3
  } ped_state_e;

  // Exactly one of {red, yellow, green} may be lit at any time.
  function automatic logic lamps_one_hot(logic [2:0] lamps);
    return (lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001);
  endfunction

endpackage

// File: rtl/ped_signal_controller_if.sv
// Signal bundle between the upstream traffic-light logic / pedestrian
// button and the pedestrian controller.
interface ped_signal_controller_if;

  logic       enable;
  logic       ped_button;
  logic       red;
  logic       yellow;
  logic       green;
  logic       walk;
  logic       flash_dont_walk;
  logic       dont_walk;
  logic [3:0] countdown;
  logic       request_pending;
  logic       fault;

  modport master (
    output enable, ped_button, red, yellow, green,
    input  walk, flash_dont_walk, dont_walk, countdown, request_pending, fault
  );

  modport slave (
    input  enable, ped_button, red, yellow, green,
    output walk, flash_dont_walk, dont_walk, countdown, request_pending, fault
  );

endinterface

// File: rtl/ped_button_debounce.sv
// Two-flop synchronizer followed by a level debouncer: the output only takes
// a new level after DEBOUNCE_CYCLES consecutive synchronized samples agree.
module ped_button_debounce
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic [7:0] cnt_q, cnt_d;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian crossing controller: latches debounced requests, grants WALK on
// the next red entry, flashes a countdown, and traps lamp-input faults.
module ped_signal_controller
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned WALK_CYCLES     = DEF_WALK_CYCLES,
  parameter int unsigned FLASH_CYCLES    = DEF_FLASH_CYCLES
) (
  input logic                    clk,
  input logic                    reset,
  ped_signal_controller_if.slave bus
);

  localparam logic [7:0] WALK_LAST  = 8'(WALK_CYCLES - 1);
  localparam logic [3:0] FLASH_LAST = 4'(FLASH_CYCLES - 1);

  ped_state_e state_q, state_d;
  logic [7:0] walk_tmr_q, walk_tmr_d;
  logic [3:0] countdown_q, countdown_d;
  logic       pending_q, pending_d;
  logic       fault_q, fault_d;
  logic       red_prev_q, deb_prev_q;
  logic       walk_q, flash_q, dont_walk_q;

  logic deb_level, deb_rise, red_rise, lamps_ok, walk_entry;

  ped_button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (bus.ped_button),
    .level_o (deb_level)
  );

  assign deb_rise = deb_level & ~deb_prev_q;
  assign red_rise = bus.red & ~red_prev_q;
  assign lamps_ok = lamps_one_hot({bus.red, bus.yellow, bus.green});

  always_comb begin
    state_d     = state_q;
    walk_tmr_d  = walk_tmr_q;
    countdown_d = countdown_q;
    fault_d     = fault_q;
    walk_entry  = 1'b0;

    if (!bus.enable) begin
      state_d     = ST_IDLE;
      walk_tmr_d  = '0;
      countdown_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:     if (pending_q) state_d = ST_WAIT_RED;
        ST_WAIT_RED: if (red_rise) begin
          state_d    = ST_WALK;
          walk_tmr_d = WALK_LAST;
          walk_entry = 1'b1;
        end
        ST_WALK: begin
          if (walk_tmr_q == '0) begin
            state_d     = ST_FLASH;
            countdown_d = FLASH_LAST;
          end else begin
            walk_tmr_d = walk_tmr_q - 8'd1;
          end
        end
        ST_FLASH: begin
          if (countdown_q == '0) state_d     = ST_IDLE;
          else                   countdown_d = countdown_q - 4'd1;
        end
        default: state_d = ST_IDLE;
      endcase

      // Losing red while pedestrians are crossing is unsafe: abort and flag.
      if ((state_q == ST_WALK || state_q == ST_FLASH) && !bus.red) begin
        state_d     = ST_IDLE;
        walk_tmr_d  = '0;
        countdown_d = '0;
        fault_d     = 1'b1;
      end
    end

    if (!lamps_ok) begin
      state_d     = ST_IDLE;
      walk_tmr_d  = '0;
      countdown_d = '0;
      fault_d     = 1'b1;
      walk_entry  = 1'b0;
    end
  end

  // A press landing on the WALK-entry cycle wins over the clear and is kept
  // for the following red phase.
  assign pending_d = deb_rise | (pending_q & ~walk_entry);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      walk_tmr_q  <= '0;
      countdown_q <= '0;
      pending_q   <= 1'b0;
      fault_q     <= 1'b0;
      red_prev_q  <= 1'b0;
      deb_prev_q  <= 1'b0;
      walk_q      <= 1'b0;
      flash_q     <= 1'b0;
      dont_walk_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      walk_tmr_q  <= walk_tmr_d;
      countdown_q <= countdown_d;
      pending_q   <= pending_d;
      fault_q     <= fault_d;
      red_prev_q  <= bus.red;
      deb_prev_q  <= deb_level;
      walk_q      <= (state_d == ST_WALK);
      flash_q     <= (state_d == ST_FLASH);
      dont_walk_q <= (state_d == ST_IDLE) || (state_d == ST_WAIT_RED);
    end
  end

  assign bus.walk            = walk_q;
  assign bus.flash_dont_walk = flash_q;
  assign bus.dont_walk       = dont_walk_q;
  assign bus.countdown       = countdown_q;
  assign bus.request_pending = pending_q;
  assign bus.fault           = fault_q;

endmodule

// File: tb/tb_ped_signal_controller.sv
// Scoreboard bench for ped_signal_controller: expected output vectors are
// queued with the stimulus and compared when the DUT outputs are sampled.
module tb_ped_signal_controller;

  localparam int DEB   = 4;
  localparam int WALK  = 6;
  localparam int FLASH = 5;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  ped_signal_controller_if bus ();

  ped_signal_controller #(
    .DEBOUNCE_CYCLES (DEB),
    .WALK_CYCLES     (WALK),
    .FLASH_CYCLES    (FLASH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Output vector layout: {walk, flash_dont_walk, dont_walk, countdown[3:0], request_pending, fault}
  typedef struct {
    string      tag;
    logic [8:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatch = 0;

  function automatic logic [8:0] v(bit w, bit f, bit d, int cd, bit p, bit flt);
    return {w, f, d, cd[3:0], p, flt};
  endfunction

  localparam logic [8:0] IDLE_V = 9'b001_0000_00;

  function automatic logic [8:0] observed();
    return {bus.walk, bus.flash_dont_walk, bus.dont_walk, bus.countdown,
            bus.request_pending, bus.fault};
  endfunction

  task automatic check(string tag, logic [8:0] got, logic [8:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %b expected %b (walk fdw dw cd[3:0] pend fault)", tag, got, exp);
    end
  endtask

  task automatic push(string tag, logic [8:0] vec);
    exp_t e;
    e.tag = tag;
    e.vec = vec;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observed(), e.vec);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change right after it.
  task automatic tick();
    @(negedge clk);
    drain();
  endtask

  task automatic set_lamps(bit r, bit y, bit g);
    bus.red    = r;
    bus.yellow = y;
    bus.green  = g;
  endtask

  task automatic idle_ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_and_hold(int hold, output int seen_at);
    seen_at = 0;
    bus.ped_button = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (seen_at == 0 && bus.request_pending) seen_at = i;
    end
    bus.ped_button = 1'b0;
  endtask

  task automatic run_walk_sequence(string tag, bit pend);
    for (int i = 0; i < WALK; i++) begin
      push($sformatf("%s_walk%0d", tag, i), v(1, 0, 0, 0, pend, 0));
      tick();
    end
    for (int i = 0; i < FLASH; i++) begin
      push($sformatf("%s_flash%0d", tag, i), v(0, 1, 0, FLASH - 1 - i, pend, 0));
      tick();
    end
    push($sformatf("%s_done", tag), v(0, 0, 1, 0, pend, 0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;

    reset          = 1'b1;
    bus.enable     = 1'b1;
    bus.ped_button = 1'b0;
    set_lamps(0, 0, 1);
    tick();
    push("rst_idle", IDLE_V);
    tick();
    reset = 1'b0;
    push("post_rst", IDLE_V);
    tick();

    // Normal request served on the next red entry.
    press_and_hold(8, seen);
    check("a_pend_within7", {8'b0, (seen >= 1 && seen <= 7)}, 9'd1);
    push("a_pending", v(0, 0, 1, 0, 1, 0));
    tick();
    idle_ticks(7);
    set_lamps(0, 1, 0);
    tick();
    set_lamps(1, 0, 0);
    run_walk_sequence("a", 0);

    // Two-cycle glitch must be rejected.
    set_lamps(0, 0, 1);
    tick();
    bus.ped_button = 1'b1;
    idle_ticks(2);
    bus.ped_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push($sformatf("b_glitch%0d", i), IDLE_V);
      tick();
    end

    // Press while red is already lit waits for the next red entry.
    set_lamps(0, 1, 0);
    tick();
    set_lamps(1, 0, 0);
    idle_ticks(2);
    press_and_hold(8, seen);
    for (int i = 0; i < 8; i++) begin
      push($sformatf("c_no_walk%0d", i), v(0, 0, 1, 0, 1, 0));
      tick();
    end
    set_lamps(0, 0, 1);
    push("c_green", v(0, 0, 1, 0, 1, 0));
    tick();
    set_lamps(0, 1, 0);
    push("c_yellow", v(0, 0, 1, 0, 1, 0));
    tick();
    set_lamps(1, 0, 0);
    run_walk_sequence("c", 0);

    // Press whose debounced edge coincides with WALK entry is re-latched,
    // then an async reset mid-FLASH clears everything immediately.
    set_lamps(0, 0, 1);
    tick();
    press_and_hold(8, seen);
    idle_ticks(8);
    bus.ped_button = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      push($sformatf("d_wait%0d", i), v(0, 0, 1, 0, 1, 0));
      tick();
      if (i == 5) set_lamps(0, 1, 0);
      if (i == 6) set_lamps(1, 0, 0);
    end
    for (int i = 7; i <= 12; i++) begin
      push($sformatf("d_relatch_walk%0d", i), v(1, 0, 0, 0, 1, 0));
      tick();
      if (i == 8) bus.ped_button = 1'b0;
    end
    push("d_flash4", v(0, 1, 0, 4, 1, 0));
    tick();
    push("d_flash3", v(0, 1, 0, 3, 1, 0));
    tick();
    #3 reset = 1'b1;
    #1 push("d_async_rst", IDLE_V);
    drain();
    push("d_rst_held", IDLE_V);
    tick();
    reset = 1'b0;
    push("d_rst_release", IDLE_V);
    tick();

    // enable=0 in WAIT_RED: request retained, served after re-enable.
    set_lamps(0, 0, 1);
    tick();
    press_and_hold(8, seen);
    idle_ticks(8);
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("e_disabled%0d", i), v(0, 0, 1, 0, 1, 0));
      tick();
    end
    set_lamps(0, 1, 0);
    push("e_dis_yellow", v(0, 0, 1, 0, 1, 0));
    tick();
    set_lamps(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      push($sformatf("e_dis_red%0d", i), v(0, 0, 1, 0, 1, 0));
      tick();
    end
    set_lamps(0, 0, 1);
    push("e_dis_green", v(0, 0, 1, 0, 1, 0));
    tick();
    bus.enable = 1'b1;
    push("e_reenable0", v(0, 0, 1, 0, 1, 0));
    tick();
    push("e_reenable1", v(0, 0, 1, 0, 1, 0));
    tick();
    set_lamps(0, 1, 0);
    push("e_yellow", v(0, 0, 1, 0, 1, 0));
    tick();
    set_lamps(1, 0, 0);
    run_walk_sequence("e", 0);

    // Red drops during the third WALK cycle -> abort with sticky fault.
    set_lamps(0, 0, 1);
    tick();
    press_and_hold(8, seen);
    idle_ticks(8);
    set_lamps(0, 1, 0);
    tick();
    set_lamps(1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      push($sformatf("f_walk%0d", i), v(1, 0, 0, 0, 0, 0));
      tick();
    end
    set_lamps(0, 0, 1);
    push("f_red_drop", v(0, 0, 1, 0, 0, 1));
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) set_lamps(0, 1, 0);
      if (i == 3) set_lamps(1, 0, 0);
      push($sformatf("f_sticky%0d", i), v(0, 0, 1, 0, 0, 1));
      tick();
    end
    reset = 1'b1;
    push("f_reset_clears", IDLE_V);
    tick();
    reset = 1'b0;
    set_lamps(0, 0, 1);
    push("f_after_reset", IDLE_V);
    tick();

    // red and green together for one cycle -> fault, back in IDLE.
    set_lamps(1, 0, 1);
    push("g_not_onehot", v(0, 0, 1, 0, 0, 1));
    tick();
    set_lamps(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("g_sticky%0d", i), v(0, 0, 1, 0, 0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/ped_signal_controller.md
PED_SIGNAL_CONTROLLER -- requirements
Module: ped_signal_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 4, cycles ped_button must be stable before a level change is accepted (1..255).
REQ-002 Parameter WALK_CYCLES, 6, cycles walk is held (1..255).
REQ-003 Parameter FLASH_CYCLES, 5, cycles of flashing don't-walk with countdown (1..16).
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port enable  input  1  high = controller operates; low = forced safe state.
REQ-007 Port ped_button  input  1  raw asynchronous pedestrian push-button, active-high.
REQ-008 Port red, yellow, green  input  1 each  vehicle lamp outputs of the traffic light state machine upstream.
REQ-009 Port walk  output  1  walk lamp.
REQ-010 Port flash_dont_walk  output  1  flashing don't-walk phase indicator.
REQ-011 Port dont_walk  output  1  steady don't-walk lamp.
REQ-012 Port countdown  output  4  remaining flash cycles minus one; 0 outside FLASH.
REQ-013 Port request_pending  output  1  a debounced press is latched and not yet served.
REQ-014 Port fault  output  1  sticky: lamp inputs not one-hot, or red dropped during WALK/FLASH.

Function
REQ-015 ped_button SHALL pass a 2-flop synchronizer, then debounce: accepted level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-016 A rising edge of the debounced button SHALL set request_pending the following cycle; further presses while set have no effect.
REQ-017 FSM states: IDLE, WAIT_RED, WALK, FLASH; exactly one of walk/flash_dont_walk/dont_walk SHALL be high every cycle (walk in WALK, flash_dont_walk in FLASH, dont_walk otherwise).
REQ-018 IDLE -> WAIT_RED when request_pending=1.
REQ-019 WAIT_RED -> WALK only on a red rising edge (red=1 this cycle, 0 previous cycle); request_pending clears on that transition; a press arriving while red is already high waits for the next red entry.
REQ-020 WALK lasts exactly WALK_CYCLES cycles, then FLASH.
REQ-021 FLASH: countdown loads FLASH_CYCLES-1 on entry, decrements each cycle; after the cycle showing 0 -> IDLE.
REQ-022 If red=0 in any WALK or FLASH cycle: next state IDLE, fault set, countdown 0, request_pending unchanged.
REQ-023 If {red,yellow,green} is not one-hot in any cycle: fault set, next state IDLE.
REQ-024 fault clears only on reset.
REQ-025 enable=0: next state IDLE, counters cleared, request latching continues; on enable rising, normal operation resumes from IDLE.
REQ-026 A press whose debounced edge lands in the same cycle as the WALK entry SHALL re-latch request_pending (served next red entry).

Reset
REQ-027 While reset is high: state IDLE, dont_walk=1, walk=0, flash_dont_walk=0, countdown=0, request_pending=0, fault=0, synchronizer/debounce state 0, red-edge history 0.
REQ-028 Reset assertion mid-WALK/FLASH SHALL drive outputs to reset values immediately, without waiting for clk.
REQ-029 First red rising edge is detectable in the first clock after reset release.

Structure
REQ-030 Shared package ped_pkg SHALL hold the FSM state encoding and default parameter constants.
REQ-031 Synchronizer plus debounce SHALL be a sub-module ped_button_debounce (clk, reset, raw in, debounced level out).

Verification (DEBOUNCE_CYCLES=4, WALK_CYCLES=6, FLASH_CYCLES=5, 20 ns clock)
REQ-032 Press held 8 cycles while green -> request_pending=1 within 7 cycles of press; red rises -> walk=1 next cycle for 6 cycles, then flash_dont_walk with countdown 4,3,2,1,0, then dont_walk, request_pending=0.
REQ-033 2-cycle glitch on ped_button -> request_pending stays 0, dont_walk stays 1.
REQ-034 Press while red already high -> no walk until red falls and rises again.
REQ-035 Red drops in 3rd WALK cycle -> dont_walk=1 next cycle, fault=1 and sticky until reset.
REQ-036 red=1 and green=1 together for one cycle -> fault=1, state IDLE.
REQ-037 Async reset pulse mid-FLASH (between edges) -> dont_walk=1, countdown=0, request_pending=0 immediately; enable=0 in WAIT_RED -> dont_walk held, request retained, walk after enable=1 and next red entry.
